// File: rtl/alu_pkg.sv
// alu_pkg: shared op encodings, alu_ctl constants and FSM state type for the serial ALU.
package alu_pkg;
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_LESS = 2'b11;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/alu_cell.sv
// alu_cell: one-bit ALU slice with invertible operands, full adder and less passthrough.
module alu_cell
  import alu_pkg::*;
(
  input logic a,
  input logic b,
  input logic a_invert,
  input logic b_invert,
  input logic carry_in,
  input logic less,
  input logic [1:0] op,
  output logic result,
  output logic sum,
  output logic carry_out
);
  logic aa, bb;
  assign aa = a ^ a_invert;
  assign bb = b ^ b_invert;
  assign sum = aa ^ bb ^ carry_in;
  assign carry_out = (aa & bb) | (aa & carry_in) | (bb & carry_in);
  assign result = op == OP_AND ? aa & bb : op == OP_OR ? aa | bb : op == OP_ADD ? sum : less;
endmodule

// File: rtl/serial_alu_ctrl.sv
// serial_alu_ctrl: bit-serial ALU, one bit per cycle LSB first through a single alu_cell.
module serial_alu_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  input logic in_valid,
  output logic in_ready,
  input logic [3:0] alu_ctl,
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  output logic out_valid,
  input logic out_ready,
  output logic [WIDTH-1:0] result,
  output logic zero,
  output logic overflow,
  output logic carry_out
);
  localparam int IW = $clog2(WIDTH);
  state_t state;
  logic [WIDTH-1:0] a_q, b_q, res_next;
  logic [3:0] ctl_q;
  logic [IW-1:0] idx;
  logic carry, last, cell_res, cell_sum, cell_cout;
  assign last = idx == IW'(WIDTH - 1);
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  alu_cell u_cell (
    .a(a_q[idx]),
    .b(b_q[idx]),
    .a_invert(ctl_q[3]),
    .b_invert(ctl_q[2]),
    .carry_in(carry),
    .less(1'b0),
    .op(ctl_q[1:0]),
    .result(cell_res),
    .sum(cell_sum),
    .carry_out(cell_cout)
  );
  // set-on-less-than takes the sign of the difference into bit 0 on the last bit
  always_comb begin
    res_next = result;
    res_next[idx] = cell_res;
    res_next[0] = last && ctl_q[1:0] == OP_LESS ? cell_sum : res_next[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result <= '0;
      zero <= 1'b0;
      overflow <= 1'b0;
      carry_out <= 1'b0;
      carry <= 1'b0;
      idx <= '0;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_q <= a;
          b_q <= b;
          ctl_q <= alu_ctl;
          idx <= '0;
          carry <= alu_ctl[2];
          state <= RUN;
        end
        RUN: begin
          result <= res_next;
          carry <= cell_cout;
          idx <= idx + 1'b1;
          if (last) begin
            state <= DONE;
            zero <= res_next == '0;
            overflow <= carry ^ cell_cout;
            carry_out <= cell_cout;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_ctrl.sv
// tb_serial_alu_ctrl: scoreboard bench for the bit-serial ALU controller.
module tb_serial_alu_ctrl;
  import alu_pkg::*;
  localparam int W = 32;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0] alu_ctl = '0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, zero, overflow, carry_out;
  logic [W-1:0] result;
  typedef struct packed {logic [W-1:0] r; logic z, v, c;} exp_t;
  exp_t sb[$];
  int total = 0, bad = 0;
  serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_ctl(alu_ctl),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  function automatic exp_t model(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] xa, yb, lo;
    logic [W:0] s;
    exp_t e;
    xa = ctl[3] ? ~x : x;
    yb = ctl[2] ? ~y : y;
    s = {1'b0, xa} + {1'b0, yb} + {{W{1'b0}}, ctl[2]};
    lo = {1'b0, xa[W-2:0]} + {1'b0, yb[W-2:0]} + {{(W-1){1'b0}}, ctl[2]};
    case (ctl[1:0])
      2'b00: e.r = xa & yb;
      2'b01: e.r = xa | yb;
      2'b10: e.r = s[W-1:0];
      default: e.r = {{(W-1){1'b0}}, s[W-1]};
    endcase
    e.z = e.r == '0;
    e.c = s[W];
    e.v = lo[W-1] ^ s[W];
    return e;
  endfunction
  task automatic collect(input bit rel);
    int lat = 0;
    exp_t e;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    total++;
    if (lat !== 32) begin bad++; $display("FAIL latency got=%0d exp=32", lat); end
    e = sb.size() > 0 ? sb.pop_front() : '0;
    total++;
    if (result !== e.r) begin bad++; $display("FAIL result got=%h exp=%h", result, e.r); end
    total++;
    if (zero !== e.z) begin bad++; $display("FAIL zero got=%b exp=%b", zero, e.z); end
    total++;
    if (overflow !== e.v) begin bad++; $display("FAIL overflow got=%b exp=%b", overflow, e.v); end
    total++;
    if (carry_out !== e.c) begin bad++; $display("FAIL carry_out got=%b exp=%b", carry_out, e.c); end
    if (rel) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      total++;
      if ({in_ready, out_valid} !== 2'b10) begin
        bad++;
        $display("FAIL release in_ready/out_valid got=%b%b exp=10", in_ready, out_valid);
      end
    end
  endtask
  task automatic issue(input logic [3:0] ctl, input logic [W-1:0] x, input logic [W-1:0] y, input exp_t e, input bit rel);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL accept_wait in_ready got=%b exp=1", in_ready); end
    alu_ctl = ctl;
    a = x;
    b = y;
    in_valid = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = ~x;
    b = $urandom;
    alu_ctl = 4'($urandom);
    collect(rel);
  endtask
  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL reset_hs got=%b%b exp=10", in_ready, out_valid); end
    total++;
    if ({result, zero, overflow, carry_out} !== '0) begin bad++; $display("FAIL reset_out got=%h/%b%b%b exp=0", result, zero, overflow, carry_out); end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask
  task automatic test_add;
    issue(ALU_ADD, 32'h7FFF_FFFF, 32'h1, {32'h8000_0000, 1'b0, 1'b1, 1'b0}, 1'b1);
  endtask
  task automatic test_sub;
    issue(ALU_SUB, 32'd5, 32'd5, {32'h0, 1'b1, 1'b0, 1'b1}, 1'b1);
  endtask
  task automatic test_rst_mid_run;
    @(negedge clk);
    alu_ctl = ALU_ADD;
    a = 32'h3FF;
    b = 32'h0;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL midrst_hs got=%b%b exp=10", in_ready, out_valid); end
    total++;
    if ({result, zero, overflow, carry_out} !== '0) begin bad++; $display("FAIL midrst_out got=%h/%b%b%b exp=0", result, zero, overflow, carry_out); end
    issue(ALU_ADD, 32'd2, 32'd3, {32'd5, 1'b0, 1'b0, 1'b0}, 1'b1);
  endtask
  task automatic test_slt;
    issue(ALU_SLT, 32'd3, 32'd7, {32'd1, 1'b0, 1'b0, 1'b0}, 1'b1);
    issue(ALU_SLT, 32'd7, 32'd3, {32'd0, 1'b1, 1'b0, 1'b1}, 1'b1);
    issue(ALU_SLT, 32'hFFFF_FFFF, 32'd1, {32'd1, 1'b0, 1'b0, 1'b1}, 1'b1);
  endtask
  task automatic test_nor;
    issue(ALU_NOR, 32'h0F0F_0F0F, 32'h00FF_00FF, {32'hF000_F000, 1'b0, 1'b0, 1'b1}, 1'b1);
  endtask
  task automatic test_hold;
    issue(ALU_ADD, 32'd100, 32'd23, {32'd123, 1'b0, 1'b0, 1'b0}, 1'b0);
    alu_ctl = ALU_ADD;
    a = 32'd9;
    b = 32'd4;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({result, in_ready, out_valid} !== {32'd123, 2'b01}) begin
        bad++;
        $display("FAIL hold cyc=%0d got=%h/%b%b exp=%h/01", i, result, in_ready, out_valid, 32'd123);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++;
    if ({in_ready, out_valid} !== 2'b10) begin bad++; $display("FAIL done_to_idle got=%b%b exp=10", in_ready, out_valid); end
    sb.push_back({32'd13, 1'b0, 1'b0, 1'b0});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL accept_after_idle in_ready got=%b exp=0", in_ready); end
    collect(1'b1);
  endtask
  task automatic test_back_to_back;
    logic [3:0] c;
    logic [W-1:0] x, y;
    for (int i = 0; i < 16; i++) begin
      c = 4'(i);
      x = $urandom;
      y = (i % 4 == 3) ? x : $urandom;
      issue(c, x, y, model(c, x, y), 1'b1);
    end
  endtask
  initial begin
    test_reset;
    test_add;
    test_sub;
    test_rst_mid_run;
    test_slt;
    test_nor;
    test_hold;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
